mult_rr_sched: RTL

- Round-robin scheduler that shares one Multiplier_top instance among NUM_REQ requesters.
- Multiplier_top is the combinational 16x16 Booth / Wallace / CLA32 datapath.
- Operands are registered before the multiplier and the product is registered after it; at most one operation is in flight.
- Sits between the requesting engines and Multiplier_top; it is the only block that drives Multiplier_top's inputs.

---
 rtl/mult_rr_sched_pkg.sv | 29 ++
 rtl/mult_rr_sched_arbiter.sv | 28 ++
 rtl/mult_rr_sched_mult.sv | 87 ++++++++
 rtl/mult_rr_sched.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mult_rr_sched_pkg.sv
// rtl/mult_rr_sched_pkg.sv - shared widths, FSM encoding and carry-save helper for mult_rr_sched
package mult_rr_sched_pkg;

    localparam int OP_W  = 16;
    localparam int RES_W = 32;

    // 2'd3 is unused and recovers to ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [RES_W-1:0] s;
        logic [RES_W-1:0] c;
    } csa_t;

    // 3:2 compressor over whole rows; the carry row is pre-shifted into place
    function automatic csa_t csa3(input logic [RES_W-1:0] x,
                                  input logic [RES_W-1:0] y,
                                  input logic [RES_W-1:0] z);
        csa_t r;
        r.s = x ^ y ^ z;
        r.c = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/mult_rr_sched_arbiter.sv
// rtl/mult_rr_sched_arbiter.sv - combinational round-robin pick starting after last_gnt
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   last_gnt,
    output logic [GNT_W-1:0]   gnt,
    output logic               gnt_valid
);

    logic [GNT_W-1:0] cand;

    // Walk last_gnt+1 .. last_gnt+NUM_REQ (mod NUM_REQ); first asserted request wins
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GNT_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!gnt_valid && req[cand]) begin
                gnt       = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_rr_sched_mult.sv
// rtl/mult_rr_sched_mult.sv - combinational 16x16 signed Booth radix-4 / Wallace / CLA32 multiplier
module Multiplier_top
    import mult_rr_sched_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] p
);

    logic [OP_W:0]    bx;
    logic [OP_W+1:0]  a1;
    logic [OP_W+1:0]  a2;
    logic [RES_W-1:0] rows [9];
    logic [RES_W-1:0] corr;
    logic [2:0]       sel;
    logic             neg;
    logic [OP_W+1:0]  mag;
    logic [OP_W+1:0]  pp;

    assign bx = {b, 1'b0};
    assign a1 = {{2{a[OP_W-1]}}, a};
    assign a2 = {a[OP_W-1], a, 1'b0};

    // Booth digits: negative digits use one's complement plus a +1 in the correction row
    always_comb begin
        corr = '0;
        sel  = '0;
        neg  = 1'b0;
        mag  = '0;
        pp   = '0;
        for (int i = 0; i < 9; i++) rows[i] = '0;
        for (int i = 0; i < 8; i++) begin
            sel = bx[2*i +: 3];
            neg = sel[2] & ~(sel[1] & sel[0]);
            if (sel[1] ^ sel[0])
                mag = a1;
            else if (sel == 3'b100 || sel == 3'b011)
                mag = a2;
            else
                mag = '0;
            pp          = neg ? ~mag : mag;
            rows[i]     = {{(RES_W-OP_W-2){pp[OP_W+1]}}, pp} << (2*i);
            corr[2*i]   = neg;
        end
        rows[8] = corr;
    end

    csa_t l1_0, l1_1, l1_2, l2_0, l2_1, l3, l4;

    assign l1_0 = csa3(rows[0], rows[1], rows[2]);
    assign l1_1 = csa3(rows[3], rows[4], rows[5]);
    assign l1_2 = csa3(rows[6], rows[7], rows[8]);
    assign l2_0 = csa3(l1_0.s, l1_0.c, l1_1.s);
    assign l2_1 = csa3(l1_1.c, l1_2.s, l1_2.c);
    assign l3   = csa3(l2_0.s, l2_0.c, l2_1.s);
    assign l4   = csa3(l3.s, l3.c, l2_1.c);

    logic [RES_W-1:0] g, pr, c;
    logic [7:0]       bg, bp;
    logic [8:0]       bc;

    // Two-level carry lookahead: 4-bit groups, group carries resolved from group G/P
    always_comb begin
        g  = l4.s & l4.c;
        pr = l4.s ^ l4.c;
        bg = '0;
        bp = '0;
        bc = '0;
        c  = '0;
        for (int j = 0; j < 8; j++) begin
            bg[j] = 1'b0;
            bp[j] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                bg[j] = g[4*j+k] | (pr[4*j+k] & bg[j]);
                bp[j] = bp[j] & pr[4*j+k];
            end
        end
        for (int j = 0; j < 8; j++) bc[j+1] = bg[j] | (bp[j] & bc[j]);
        for (int j = 0; j < 8; j++) begin
            c[4*j] = bc[j];
            for (int k = 0; k < 3; k++)
                c[4*j+k+1] = g[4*j+k] | (pr[4*j+k] & c[4*j+k]);
        end
        p = pr ^ c;
    end

endmodule

// File: rtl/mult_rr_sched.sv
// rtl/mult_rr_sched.sv - round-robin sharing of one Multiplier_top; optional MULT_RR_SCHED_STATS_EN counters
module mult_rr_sched
    import mult_rr_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [RES_W-1:0]        resp_data,
    output logic [GNT_W-1:0]        resp_id,
    output logic                    busy
`ifdef MULT_RR_SCHED_STATS_EN
    ,
    output logic [15:0]             op_count,
    output logic [15:0]             stall_cycles
`endif
);

    state_t           state_q, state_d;
    logic [GNT_W-1:0] last_gnt_q;
    logic [GNT_W-1:0] owner_q;
    logic [GNT_W-1:0] gnt;
    logic             gnt_valid;
    logic [OP_W-1:0]  op_a_q, op_b_q;
    logic [RES_W-1:0] res_q;
    logic [RES_W-1:0] mult_p;
    logic             accept;
    logic             resp_hs;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .last_gnt  (last_gnt_q),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    // Only the registered operands of the owner ever reach the multiplier
    Multiplier_top u_mult (
        .a (op_a_q),
        .b (op_b_q),
        .p (mult_p)
    );

    assign accept  = (state_q == ST_IDLE) && gnt_valid && req_valid[gnt];
    assign resp_hs = (state_q == ST_RESP) && resp_ready[owner_q];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs; req_ready is masked by rst_n so it is 0 during reset
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = '0;
        resp_id    = '0;
        busy       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) req_ready[gnt] = rst_n;
                if (accept)    state_d = ST_CALC;
            end
            ST_CALC: begin
                busy    = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                busy                = 1'b1;
                resp_valid[owner_q] = 1'b1;
                resp_data           = res_q;
                resp_id             = owner_q;
                if (resp_ready[owner_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture on accept, product capture in CALC, fairness pointer on response handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_q      <= '0;
            owner_q    <= '0;
            last_gnt_q <= GNT_W'(NUM_REQ - 1);
        end else begin
            if (accept) begin
                op_a_q  <= req_a[OP_W*gnt +: OP_W];
                op_b_q  <= req_b[OP_W*gnt +: OP_W];
                owner_q <= gnt;
            end
            if (state_q == ST_CALC) res_q <= mult_p;
            if (resp_hs)            last_gnt_q <= owner_q;
        end
    end

`ifdef MULT_RR_SCHED_STATS_EN
    // Saturating counts of completed operations and of back-pressured response cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count     <= '0;
            stall_cycles <= '0;
        end else begin
            if (resp_hs && op_count != 16'hFFFF)
                op_count <= op_count + 16'd1;
            if (state_q == ST_RESP && !resp_ready[owner_q] && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule
